// File: rtl/rv32_pkg.sv
// Shared RV32I encoding definitions: instruction formats, major opcodes and the NOP word.
// Also holds the sign-uniformity helper used by the immediate range checks.
package rv32_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_OP_IMM = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    // True when v[31:lo] are all equal, i.e. v fits as a sign-extended (lo+1)-bit value.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lo);
        logic [31:0] s;
        s = $unsigned($signed(v) >>> lo);
        return (s == 32'h0) || (s == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/enc_skid_fifo.sv
// Two-entry valid/ready FIFO holding encoded words; owns count, pointers and out_valid.
// Handshake: a beat transfers on a rising edge where valid && ready; ready depends only on count.
module enc_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I fields and an immediate into an instruction word, buffered by a 2-entry FIFO.
// Define ENC_RANGE_CHECK_EN to flag immediates that do not fit their format.
module inst_encoder
    import rv32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    logic [31:0]      w_inst;
    logic             w_fmt_bad;
    logic             w_range_bad;
    logic             w_err;
    logic             w_push;
    logic [32:0]      w_fifo_out;
    logic [CNT_W-1:0] r_err_count;

    always_comb begin
        w_inst    = NOP_INST;
        w_fmt_bad = 1'b0;
        case (in_fmt)
            FMT_R: w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: w_inst = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, in_opcode};
            default: begin
                w_inst    = NOP_INST;
                w_fmt_bad = 1'b1;
            end
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    always_comb begin
        w_range_bad = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: w_range_bad = !upper_uniform(in_imm, 11);
            FMT_B:        w_range_bad = in_imm[0] || !upper_uniform(in_imm, 12);
            FMT_J:        w_range_bad = in_imm[0] || !upper_uniform(in_imm, 20);
            FMT_U:        w_range_bad = (in_imm[11:0] != 12'h000);
            default:      w_range_bad = 1'b0;
        endcase
    end
`else
    assign w_range_bad = 1'b0;
`endif

    assign w_err  = w_fmt_bad || w_range_bad;
    assign w_push = in_valid && in_ready;

    enc_skid_fifo #(
        .W (33)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({w_err, w_inst}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_fifo_out)
    );

    assign out_err   = w_fifo_out[32];
    assign out_inst  = w_fifo_out[31:0];
    assign err_count = r_err_count;

    // Saturating: once all-ones the count is pinned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_push && w_err && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: field packing, range errors, backpressure, saturation, reset flush.
// Expected values follow the ENC_RANGE_CHECK_EN setting used to build the design.
module tb_inst_encoder;

    localparam int CW = 3;
`ifdef ENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_fmt = '0;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_inst;
    logic          out_err;
    logic [CW-1:0] err_count;

    // Entry: {round_trip, fmt[2:0], err, inst_or_imm[31:0]}
    logic [36:0] exp_q[$];
    int          tests = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic        rand_rdy = 1'b0;

    inst_encoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] i);
        case (fmt)
            3'd1:    return {{20{i[31]}}, i[31:20]};
            3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    return {i[31:12], 12'h000};
            3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard: compare every transfer that will happen at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_inst, 32'hxxxxxxxx);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("out_err", {31'h0, out_err}, {31'h0, e[32]});
                if (e[36])
                    check("round_trip_imm", decode_imm(e[35:33], out_inst), e[31:0]);
                else
                    check("out_inst", out_inst, e[31:0]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic [36:0] e);
        int t = 0;
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'h0, 32'h1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            if (e[32]) exp_cnt = (exp_cnt == (1 << CW) - 1) ? exp_cnt : exp_cnt + 1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    function automatic logic [36:0] ex(input logic [31:0] inst, input logic err);
        return {1'b0, 3'd0, err, inst};
    endfunction

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_err", {31'h0, out_err}, 32'h0);
        check("rst_err_count", {29'h0, err_count}, 32'h0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'h0, in_ready}, 32'h1);

        // One-cycle latency into an empty FIFO.
        out_ready = 1'b1;
        push(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, ex(32'hFFF00093, 1'b0));
        check("latency_valid", {31'h0, out_valid}, 32'h1);
        check("latency_inst", out_inst, 32'hFFF00093);

        push(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, ex(32'h402081B3, 1'b0));
        push(3'd2, 7'h23, 5'd9, 5'd2, 5'd5, 3'd2, 7'h55, 32'hFFFF_FFFC, ex(32'hFE512E23, 1'b0));
        push(3'd3, 7'h63, 5'd31, 5'd0, 5'd0, 3'd0, 7'h7F, 32'h0000_0008, ex(32'h00000463, 1'b0));
        push(3'd5, 7'h6F, 5'd1, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h0000_0800, ex(32'h001000EF, 1'b0));
        push(3'd4, 7'h37, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, ex(32'h123452B7, 1'b0));
        push(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, ex(32'h80000093, RC));
        push(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, ex(32'h80000093, 1'b0));
        push(3'd7, 7'h33, 5'd5, 5'd6, 5'd7, 3'd1, 7'h01, 32'h0000_1234, ex(32'h00000013, 1'b1));
        push(3'd6, 7'h6F, 5'd5, 5'd6, 5'd7, 3'd1, 7'h01, 32'h0000_0000, ex(32'h00000013, 1'b1));
        push(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, ex(32'h00000163, RC));
        push(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5678, ex(32'h12345037, RC));
        push(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, ex(32'h8000006F, RC));
        wait_drain();
        check("err_count_directed", {29'h0, err_count}, RC ? 32'd6 : 32'd2);

        // Backpressure: two words fill the FIFO, the third waits for a pop.
        out_ready = 1'b0;
        push(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, ex(32'h00500093, 1'b0));
        push(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd6, ex(32'h00600113, 1'b0));
        check("full_in_ready", {31'h0, in_ready}, 32'h0);
        check("full_head", out_inst, 32'h00500093);
        repeat (3) @(posedge clk);
        #1;
        check("stall_stable_inst", out_inst, 32'h00500093);
        check("stall_stable_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        push(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7, ex(32'h00700193, 1'b0));
        wait_drain();

        // Saturation of the narrow error counter.
        for (int k = 0; k < 8; k++)
            push(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, ex(32'h00000013, 1'b1));
        wait_drain();
        check("err_count_sat", {29'h0, err_count}, 32'h7);
        check("err_count_model", {29'h0, err_count}, 32'(exp_cnt));

        // Random legal immediates must survive decode-stage extraction.
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  f;
            logic [31:0] r;
            logic [31:0] imm;
            f = 3'($urandom_range(1, 5));
            r = $urandom;
            case (f)
                3'd1, 3'd2: imm = {{20{r[11]}}, r[11:0]};
                3'd3:       imm = {{19{r[12]}}, r[12:1], 1'b0};
                3'd4:       imm = {r[31:12], 12'h000};
                default:    imm = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            push(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), imm, {1'b1, f, 1'b0, imm});
        end
        rand_rdy = 1'b0;
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-stream flushes buffered words immediately.
        out_ready = 1'b0;
        push(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, ex(32'h00100093, 1'b0));
        push(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, ex(32'h00200113, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("flush_out_valid", {31'h0, out_valid}, 32'h0);
        check("flush_in_ready", {31'h0, in_ready}, 32'h1);
        check("flush_err_count", {29'h0, err_count}, 32'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_flush_inst", out_inst, 32'h0);
        check("post_flush_valid", {31'h0, out_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Packs decoded RV32I instruction fields and a 32-bit immediate into a 32-bit instruction word. It is the inverse of the immediate-extraction logic in the decode stage: for any legal input, running the decode-stage immediate extraction on `out_inst` returns the original `imm`. It sits in the self-check/program-loader path, where it feeds generated instructions into instruction memory and checks that decode round-trips correctly. It uses valid/ready handshakes on both sides and has a 2-entry output buffer.

## Interface

Parameters:
- `CNT_W`, default 16: width of the error counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: input fields are valid.
- `in_ready`, out, 1: block can accept an input this cycle.
- `in_fmt`, in, 3: format; 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `in_opcode`, in, 7: major opcode, placed at bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2`, in, 5 each: register fields.
- `in_funct3`, in, 3; `in_funct7`, in, 7: function fields.
- `in_imm`, in, 32: immediate value, sign-extended form (U format: the full upper value).
- `out_valid`, out, 1: `out_inst` and `out_err` are valid.
- `out_ready`, in, 1: downstream accepts the output.
- `out_inst`, out, 32: encoded instruction.
- `out_err`, out, 1: the immediate was out of range for its format, or the format code was illegal.
- `err_count`, out, `CNT_W`: saturating count of accepted inputs that produced `out_err`=1.

## Operation

- An input is accepted on a rising edge where `in_valid && in_ready`.
- The encoding is computed combinationally and written into the FIFO tail in the same edge.
- Field placement:
  - rd at [11:7], funct3 at [14:12], rs1 at [19:15], rs2 at [24:20], funct7 at [31:25], where the format uses the field.
  - I: `imm[11:0]` at [31:20].
  - S: `imm[11:5]` at [31:25], `imm[4:0]` at [11:7].
  - B: `imm[12]` at [31], `imm[10:5]` at [30:25], `imm[4:1]` at [11:8], `imm[11]` at [7].
  - U: `imm[31:12]` at [31:12].
  - J: `imm[20]` at [31], `imm[10:1]` at [30:21], `imm[11]` at [20], `imm[19:12]` at [19:12].
  - R: `in_imm` is ignored.
- Fields a format does not use are ignored; they never leak into the word.
- Illegal `in_fmt` (6 or 7): `out_inst` = 32'h00000013 (NOP) and `out_err`=1, always, independent of the configuration macro.
- Range rules, applied when the range check is compiled in:
  - I and S: `imm[31:11]` must be all-equal.
  - B: `imm[0]`=0 and `imm[31:12]` all-equal.
  - J: `imm[0]`=0 and `imm[31:20]` all-equal.
  - U: `imm[11:0]`=0.
  - R: never an error.
- On a range error the word is still encoded from the truncated bits and `out_err`=1.
- `err_count` increments on each accepted input with `out_err`=1 and saturates at all-ones.

## Timing

- Reset values: FIFO count 0, `out_valid`=0, `out_inst`=0, `out_err`=0, `err_count`=0. `in_ready`=1 one cycle after reset release.
- Reset asserted mid-operation flushes both entries asynchronously; buffered words are lost.
- Latency: an input accepted at edge N appears at `out_valid` after edge N (1 cycle) if the FIFO was empty.
- `in_ready` = (count != 2). It is combinational from registered state only and does not depend on `out_ready`.
- Push and pop in the same edge at count 1: count stays 1 and order is preserved.
- At count 2 no push is possible, because `in_ready`=0.
- `out_inst` and `out_err` stay stable while `out_valid && !out_ready`.
- Full throughput of 1 word/cycle when `out_ready` is held high.

## Configuration

- `ENC_RANGE_CHECK_EN` defined: range rules are enforced, `out_err` reflects range and format errors, and `err_count` is active.
- Not defined: only illegal-format errors set `out_err`; `err_count` still counts them. Immediates are truncated silently.

## Structure

- Shared package `rv32_pkg`: format enum (R/I/S/B/U/J), opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR), NOP constant 32'h00000013.
- One sub-module, `enc_skid_fifo`: a 2-entry, 33-bit (inst + err) valid/ready FIFO that owns count, pointers and `out_valid`.

## Test plan

- I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> `out_inst`=0xFFF00093, `out_err`=0, one cycle later.
- B, opcode 0x63, rs1=rs2=0, imm=8 -> 0x00000463. J, opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF. U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- I, imm=2048 with the macro defined -> `out_err`=1, `err_count`=1. Without the macro -> `out_err`=0, word 0x80000093 for rd=1, opcode 0x13.
- `in_fmt`=7 -> `out_inst`=0x00000013, `out_err`=1 in both builds.
- Hold `out_ready`=0 and push 3 words -> `in_ready` drops after the 2nd. Release `out_ready` -> words are drained in order and the 3rd is accepted.
- Random legal fields -> decode-stage immediate extraction of `out_inst` equals `in_imm` (U: `imm[31:12]`); reset asserted mid-stream -> `out_valid`=0 immediately.
